// File: rtl/imm_materializer.sv
// Turns a (rd, 32-bit constant) request into the shortest RV32I ADDI/LUI sequence that rebuilds it.
// One registered output slot; a LUI+ADDI pair holds the ADDI until the LUI has been taken.
module imm_materializer #(
    parameter bit LUI_ONLY_OPT = 1'b1,
    parameter bit X0_AS_NOP    = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [4:0]  reqRd,
    input  logic [31:0] reqValue,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instrOut,
    output logic        instrLast
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT1,
        EMIT2_PENDING,
        EMIT2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_addi(input logic signed [11:0] imm12,
                                             input logic [4:0] rs1,
                                             input logic [4:0] rd);
        return {imm12, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [19:0] imm20,
                                            input logic [4:0] rd);
        return {imm20, rd, 7'b0110111};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        last_q, last_d;
    logic [31:0] pend_q, pend_d;

    logic               hs;
    logic               accept;
    logic signed [11:0] lo;
    logic [19:0]        up;
    logic               fit12;
    logic               lui0;

    assign instrValid = (state_q != IDLE);
    assign instrOut   = instr_q;
    assign instrLast  = last_q;

    assign hs       = instrValid && instrReady;
    assign reqReady = rstn && ((state_q == IDLE) ||
                               (hs && last_q && (state_q != EMIT2_PENDING)));
    assign accept   = reqValid && reqReady;

    // ADDI sign-extends its immediate, so the LUI part absorbs a borrow when lo[11] is set.
    assign lo    = reqValue[11:0];
    assign up    = reqValue[31:12] + {19'd0, reqValue[11]};
    assign fit12 = (&reqValue[31:11]) || !(|reqValue[31:11]);
    assign lui0  = !fit12 && (reqValue[11:0] == 12'd0) && LUI_ONLY_OPT;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        last_d  = last_q;
        pend_d  = pend_q;

        case (state_q)
            EMIT2_PENDING: begin
                if (hs) begin
                    state_d = EMIT2;
                    instr_d = pend_q;
                    last_d  = 1'b1;
                end
            end
            EMIT1, EMIT2: begin
                if (hs) begin
                    state_d = IDLE;
                    instr_d = 32'd0;
                    last_d  = 1'b0;
                end
            end
            default: ;
        endcase

        // Acceptance only happens from IDLE or on the final handshake, so it overrides the above.
        if (accept) begin
            if (reqRd == 5'd0) begin
                if (X0_AS_NOP) begin
                    state_d = EMIT1;
                    instr_d = NOP;
                    last_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    instr_d = 32'd0;
                    last_d  = 1'b0;
                end
            end else if (fit12) begin
                state_d = EMIT1;
                instr_d = enc_addi(lo, 5'd0, reqRd);
                last_d  = 1'b1;
            end else if (lui0) begin
                state_d = EMIT1;
                instr_d = enc_lui(reqValue[31:12], reqRd);
                last_d  = 1'b1;
            end else begin
                state_d = EMIT2_PENDING;
                instr_d = enc_lui(up, reqRd);
                last_d  = 1'b0;
                pend_d  = enc_addi(lo, reqRd, reqRd);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            instr_q <= 32'd0;
            last_q  <= 1'b0;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_imm_materializer.sv
// Directed bench for imm_materializer: default instance plus one with LUI_ONLY_OPT=0, X0_AS_NOP=0.
module tb_imm_materializer;

    logic        clk;
    logic        rstn;

    logic        req_valid_a, req_ready_a, instr_valid_a, instr_ready_a, instr_last_a;
    logic [4:0]  req_rd_a;
    logic [31:0] req_value_a, instr_out_a;

    logic        req_valid_b, req_ready_b, instr_valid_b, instr_ready_b, instr_last_b;
    logic [4:0]  req_rd_b;
    logic [31:0] req_value_b, instr_out_b;

    int checks = 0;
    int errors = 0;

    imm_materializer dut_a (
        .clk        (clk),
        .rstn       (rstn),
        .reqValid   (req_valid_a),
        .reqReady   (req_ready_a),
        .reqRd      (req_rd_a),
        .reqValue   (req_value_a),
        .instrValid (instr_valid_a),
        .instrReady (instr_ready_a),
        .instrOut   (instr_out_a),
        .instrLast  (instr_last_a)
    );

    imm_materializer #(.LUI_ONLY_OPT(1'b0), .X0_AS_NOP(1'b0)) dut_b (
        .clk        (clk),
        .rstn       (rstn),
        .reqValid   (req_valid_b),
        .reqReady   (req_ready_b),
        .reqRd      (req_rd_b),
        .reqValue   (req_value_b),
        .instrValid (instr_valid_b),
        .instrReady (instr_ready_b),
        .instrOut   (instr_out_b),
        .instrLast  (instr_last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn          = 1'b1;
        req_valid_a   = 1'b0; req_rd_a = '0; req_value_a = '0; instr_ready_a = 1'b1;
        req_valid_b   = 1'b0; req_rd_b = '0; req_value_b = '0; instr_ready_b = 1'b1;
        #1 rstn = 1'b0;
        step(); step();
        chk("rst_valid", {31'd0, instr_valid_a}, 32'd0);
        chk("rst_ready", {31'd0, req_ready_a}, 32'd0);
        chk("rst_out",   instr_out_a, 32'd0);
        chk("rst_last",  {31'd0, instr_last_a}, 32'd0);
        rstn = 1'b1;
        #1;
        chk("idle_ready", {31'd0, req_ready_a}, 32'd1);

        // ADDI x5,x0,2047
        step();
        req_valid_a = 1'b1; req_rd_a = 5'd5; req_value_a = 32'h0000_07FF;
        step();
        req_valid_a = 1'b0; req_rd_a = 5'd9; req_value_a = 32'hDEAD_BEEF;
        chk("fit12_valid", {31'd0, instr_valid_a}, 32'd1);
        chk("fit12_out",   instr_out_a, 32'h7FF0_0293);
        chk("fit12_last",  {31'd0, instr_last_a}, 32'd1);
        step();
        chk("fit12_idle", {31'd0, instr_valid_a}, 32'd0);

        // LUI x10,0x12345
        req_valid_a = 1'b1; req_rd_a = 5'd10; req_value_a = 32'h1234_5000;
        step();
        req_valid_a = 1'b0;
        chk("lui0_out",  instr_out_a, 32'h1234_5537);
        chk("lui0_last", {31'd0, instr_last_a}, 32'd1);
        step();
        chk("lui0_idle", {31'd0, instr_valid_a}, 32'd0);

        // LUI x1,0x80000 then ADDI x1,x1,-2048, with downstream stalled
        req_valid_a = 1'b1; req_rd_a = 5'd1; req_value_a = 32'h7FFF_F800; instr_ready_a = 1'b0;
        step();
        req_valid_a = 1'b0;
        chk("pair_lui",       instr_out_a, 32'h8000_00B7);
        chk("pair_lui_last",  {31'd0, instr_last_a}, 32'd0);
        chk("pair_busy",      {31'd0, req_ready_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pair_hold_valid", {31'd0, instr_valid_a}, 32'd1);
            chk("pair_hold_out",   instr_out_a, 32'h8000_00B7);
            chk("pair_hold_last",  {31'd0, instr_last_a}, 32'd0);
        end
        instr_ready_a = 1'b1;
        step();
        chk("pair_addi",      instr_out_a, 32'h8000_8093);
        chk("pair_addi_last", {31'd0, instr_last_a}, 32'd1);
        step();
        chk("pair_idle", {31'd0, instr_valid_a}, 32'd0);

        // Back-to-back: -2048 then -1 into x3, second offered on the last handshake
        req_valid_a = 1'b1; req_rd_a = 5'd3; req_value_a = 32'hFFFF_F800;
        step();
        chk("neg_out",   instr_out_a, 32'h8000_0193);
        chk("b2b_ready", {31'd0, req_ready_a}, 32'd1);
        req_value_a = 32'hFFFF_FFFF;
        step();
        req_valid_a = 1'b0;
        chk("b2b_valid", {31'd0, instr_valid_a}, 32'd1);
        chk("b2b_out",   instr_out_a, 32'hFFF0_0193);
        chk("b2b_last",  {31'd0, instr_last_a}, 32'd1);
        step();
        chk("b2b_idle", {31'd0, instr_valid_a}, 32'd0);

        // rd=x0 on the NOP instance
        req_valid_a = 1'b1; req_rd_a = 5'd0; req_value_a = 32'h1234_5678;
        step();
        req_valid_a = 1'b0;
        chk("x0_nop",      instr_out_a, 32'h0000_0013);
        chk("x0_nop_last", {31'd0, instr_last_a}, 32'd1);
        step();

        // rd=x0 on the silent instance: consumed, nothing emitted
        req_valid_b = 1'b1; req_rd_b = 5'd0; req_value_b = 32'h1234_5678;
        #1;
        chk("x0_b_ready_pre", {31'd0, req_ready_b}, 32'd1);
        step();
        req_valid_b = 1'b0;
        chk("x0_b_valid",  {31'd0, instr_valid_b}, 32'd0);
        chk("x0_b_ready",  {31'd0, req_ready_b}, 32'd1);

        // LUI_ONLY_OPT=0: low-zero constant still emits LUI + ADDI x10,x10,0
        req_valid_b = 1'b1; req_rd_b = 5'd10; req_value_b = 32'h1234_5000;
        step();
        req_valid_b = 1'b0;
        chk("nolui_lui",      instr_out_b, 32'h1234_5537);
        chk("nolui_lui_last", {31'd0, instr_last_b}, 32'd0);
        step();
        chk("nolui_addi",      instr_out_b, 32'h0005_0513);
        chk("nolui_addi_last", {31'd0, instr_last_b}, 32'd1);
        step();
        chk("nolui_idle", {31'd0, instr_valid_b}, 32'd0);

        // Reset while the ADDI half is pending
        req_valid_a = 1'b1; req_rd_a = 5'd1; req_value_a = 32'h7FFF_F800; instr_ready_a = 1'b0;
        step();
        req_valid_a = 1'b0;
        chk("rst_mid_lui", instr_out_a, 32'h8000_00B7);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, instr_valid_a}, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready_a}, 32'd0);
        step();
        rstn = 1'b1; instr_ready_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mid_no_addi", {31'd0, instr_valid_a}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
